instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
- Front end of the pipelined RV32I core: owns the PC, issues fetches to instruction memory over a valid/ready handshake, and fills the IF/ID pipeline register.
- It is the responder to the pipeline control unit: it consumes stall_pc_if, stall_if_id, clear_if_id and branch redirect, and drops wrong-path responses.
- Holds at most one outstanding fetch. A one-entry hold buffer absorbs a response that arrives while IF/ID is stalled.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_VECTOR, 32'h0000_0000, PC after reset.
- NOP_INSTR, 32'h0000_0013, instruction injected as a bubble (addi x0,x0,0).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- stall_pc_if_i  in  1  freeze PC, no new request.
- stall_if_id_i  in  1  freeze IF/ID register.
- clear_if_id_i  in  1  flush IF/ID to bubble.
- branch_enable_i  in  1  redirect taken.
- branch_target_i  in  XLEN  redirect PC.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  memory accepts request.
- imem_req_addr_o  out  XLEN  fetch address (= pc_q).
- imem_rsp_valid_i  in  1  response valid, in order, ≥1 cycle after accept.
- imem_rsp_data_i  in  32  fetched instruction.
- instr_id_o  out  32  IF/ID instruction.
- pc_id_o  out  XLEN  IF/ID PC.
- pc_plus4_id_o  out  XLEN  IF/ID PC+4.
- valid_id_o  out  1  IF/ID holds a real instruction.
- fetch_busy_o  out  1  high when state is not FETCH (debug/perf).

Behaviour:
- Reset (async, asserted):
  - pc_q=RESET_VECTOR, state=FETCH, kill_q=0, hold buffer empty.
  - instr_id_o=NOP_INSTR, pc_id_o=0, pc_plus4_id_o=0, valid_id_o=0.
  - imem_req_valid_o=0 while reset is asserted.
- Reset deassertion mid-transaction: any in-flight response is ignored. The memory is reset on the same rst_n_i.
- FSM states: FETCH, WAIT_RSP, HOLD.
- FETCH:
  - imem_req_valid_o = !stall_pc_if_i && !branch_enable_i.
  - On accept (valid&&ready): latch req_pc=pc_q, pc_q<=pc_q+4 (mod 2^XLEN), go to WAIT_RSP.
- WAIT_RSP:
  - imem_req_valid_o=0.
  - On rsp_valid with kill_q=1: discard, clear kill_q, go to FETCH.
  - On rsp_valid with kill_q=0 and !stall_if_id_i: load IF/ID {rsp_data, req_pc, req_pc+4, valid=1}, go to FETCH.
  - On rsp_valid with kill_q=0 and stall_if_id_i: capture into hold buffer, go to HOLD.
- HOLD:
  - imem_req_valid_o=0.
  - When !stall_if_id_i: load IF/ID from the buffer, go to FETCH.
- IF/ID update when no instruction is delivered and !stall_if_id_i: load NOP_INSTR, valid=0 (bubble). When stall_if_id_i=1, IF/ID holds.
- Priority: reset > branch_enable_i > clear_if_id_i > stall_if_id_i/stall_pc_if_i.
- branch_enable_i=1 in any state:
  - pc_q<=branch_target_i, overriding stall_pc_if_i.
  - IF/ID<=bubble, overriding stall_if_id_i.
  - In WAIT_RSP: set kill_q. If a response arrives the same cycle, discard it, leave kill_q=0 and go to FETCH.
  - In HOLD: drop the buffer, go to FETCH.
  - No request is issued that cycle.
- clear_if_id_i alone:
  - IF/ID<=bubble.
  - An instruction delivered the same cycle from response or buffer is dropped; HOLD goes to FETCH.
  - PC is unaffected.
- stall_pc_if_i alone: suppresses new requests only. An outstanding response still completes.
- Throughput: one instruction per 2 cycles minimum with a 1-cycle memory.
- fetch_busy_o = (state != FETCH).

Optional Feature:
- Macro: IFU_MISALIGN_CHECK_EN.
- With the macro defined:
  - Adds output fetch_misaligned_o (1 bit, reset 0).
  - A redirect with branch_target_i[1:0]!=2'b00 sets fetch_misaligned_o=1 one cycle later, sticky until reset.
  - The PC is loaded with {branch_target_i[XLEN-1:2],2'b00}.
  - Issue and IF/ID behaviour are otherwise unchanged.
- Without the macro: no port is added, and the target is loaded unmodified.

Decomposition:
- Shared package risc_v_32_i_pkg gains:
  - typedef enum logic [1:0] fetch_state_e {FETCH, WAIT_RSP, HOLD}.
  - localparam NOP_INSTRUCTION = 32'h0000_0013.
  - typedef struct packed if_id_reg_t {instr, pc, pc_plus4, valid}.
- Natural sub-module: fetch_hold_buffer. It is a one-entry register with load/drain/flush and a full flag.

Test Plan:
- Reset release, memory always ready, 1-cycle response:
  - Requests go to 0x0, then 0x4, then 0x8.
  - IF/ID shows pc 0x0 with valid=1 at cycle 3 and pc 0x4 at cycle 5.
  - Bubbles with valid=0 appear in between.
- Response to 0x4 arrives while stall_if_id_i=1 for 3 cycles:
  - State is HOLD and IF/ID holds pc 0x0.
  - One cycle after the stall drops, IF/ID shows pc 0x4.
- Branch to 0x100 while in WAIT_RSP for 0x8; response arrives 2 cycles later:
  - That response is discarded.
  - The next request address is 0x100.
  - IF/ID never shows 0x8.
- Branch and response arrive in the same cycle:
  - The response is dropped and IF/ID becomes a bubble.
  - The next request is 0x100.
- stall_pc_if_i=1 in FETCH for 2 cycles with imem_req_ready_i=1:
  - imem_req_valid_o stays 0 and pc_q holds.
  - Issue resumes at the same address.
- IFU_MISALIGN_CHECK_EN build, branch to 0x102:
  - fetch_misaligned_o=1 from the next cycle and stays set.
  - The next request address is 0x100.

Source files
------------

// File: rtl/risc_v_32_i_pkg.sv
// Shared RV32I pipeline types: fetch FSM states, bubble encoding and the
// IF/ID pipeline register layout.
package risc_v_32_i_pkg;

  localparam int unsigned XLEN_P          = 32;
  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_RSP = 2'd1,
    HOLD     = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]       instr;
    logic [XLEN_P-1:0] pc;
    logic [XLEN_P-1:0] pc_plus4;
    logic              valid;
  } if_id_reg_t;

  // A bubble carries the given NOP, zero PCs and valid=0.
  function automatic if_id_reg_t if_id_bubble(input logic [31:0] nop);
    if_id_reg_t r;
    r.instr    = nop;
    r.pc       = '0;
    r.pc_plus4 = '0;
    r.valid    = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry buffer that parks a fetch response while IF/ID is stalled.
// load captures, drain or flush empties; full_o tells whether the entry is live.
module fetch_hold_buffer
  import risc_v_32_i_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_P
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            load_i,
  input  logic            drain_i,
  input  logic            flush_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            full_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o
);

  logic full_q;

  // Occupancy flag: emptying wins over loading.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      full_q <= 1'b0;
    end else if (drain_i || flush_i) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      full_q <= 1'b1;
    end
  end

  // Payload capture.
  // NOTE: the payload has no reset; it is only ever read while full_q is set,
  // so resetting it would add reset fan-out without changing behaviour.
  always_ff @(posedge clk_i) begin
    if (load_i) begin
      instr_o <= instr_i;
      pc_o    <= pc_i;
    end
  end

  assign full_o = full_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32I instruction fetch unit: owns the PC, issues single-outstanding fetches
// over a valid/ready handshake and fills the IF/ID pipeline register.
// Optional build macro IFU_MISALIGN_CHECK_EN adds fetch_misaligned_o, a sticky
// flag for redirects to non-word-aligned targets, and word-aligns the target.
module instruction_fetch_unit
  import risc_v_32_i_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_P,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [31:0]     NOP_INSTR    = NOP_INSTRUCTION
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            stall_pc_if_i,
  input  logic            stall_if_id_i,
  input  logic            clear_if_id_i,
  input  logic            branch_enable_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  output logic [31:0]     instr_id_o,
  output logic [XLEN-1:0] pc_id_o,
  output logic [XLEN-1:0] pc_plus4_id_o,
  output logic            valid_id_o,
  output logic            fetch_busy_o
`ifdef IFU_MISALIGN_CHECK_EN
  ,
  output logic            fetch_misaligned_o
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            kill_q, kill_d;
  if_id_reg_t      if_id_q, if_id_d;

  logic            req_valid;
  logic            deliver;
  logic [31:0]     deliver_instr;
  logic [XLEN-1:0] deliver_pc;
  logic            hold_load, hold_drain, hold_flush, hold_full;
  logic [31:0]     hold_instr;
  logic [XLEN-1:0] hold_pc;
  logic [XLEN-1:0] target_pc;

`ifdef IFU_MISALIGN_CHECK_EN
  logic misaligned_q;

  assign target_pc = {branch_target_i[XLEN-1:2], 2'b00};

  // Sticky flag: any redirect to a non-word-aligned target sets it until reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      misaligned_q <= 1'b0;
    end else if (branch_enable_i && (branch_target_i[1:0] != 2'b00)) begin
      misaligned_q <= 1'b1;
    end
  end

  assign fetch_misaligned_o = misaligned_q;
`else
  assign target_pc = branch_target_i;
`endif

  fetch_hold_buffer #(
    .XLEN (XLEN)
  ) u_hold_buffer (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (hold_load),
    .drain_i (hold_drain),
    .flush_i (hold_flush),
    .instr_i (imem_rsp_data_i),
    .pc_i    (req_pc_q),
    .full_o  (hold_full),
    .instr_o (hold_instr),
    .pc_o    (hold_pc)
  );

  // Next-state, PC and handshake decode; redirect beats clear beats stall.
  // NOTE: every signal driven here gets a default on the first lines so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    kill_d        = kill_q;
    deliver       = 1'b0;
    deliver_instr = imem_rsp_data_i;
    deliver_pc    = req_pc_q;
    hold_load     = 1'b0;
    hold_drain    = 1'b0;
    hold_flush    = 1'b0;
    // Gating with rst_n_i keeps the request quiet while reset is held.
    req_valid     = rst_n_i && (state_q == FETCH) && !stall_pc_if_i && !branch_enable_i;

    unique case (state_q)
      FETCH: begin
        if (req_valid && imem_req_ready_i) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          state_d  = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (imem_rsp_valid_i) begin
          // Every response ends the transaction; only a live, unflushed one is kept.
          state_d = FETCH;
          kill_d  = 1'b0;
          if (!kill_q && !branch_enable_i && !clear_if_id_i) begin
            if (stall_if_id_i) begin
              hold_load = 1'b1;
              state_d   = HOLD;
            end else begin
              deliver = 1'b1;
            end
          end
        end else if (branch_enable_i) begin
          // Response still in flight belongs to the wrong path.
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (branch_enable_i || clear_if_id_i) begin
          hold_flush = 1'b1;
          state_d    = FETCH;
        end else if (!stall_if_id_i) begin
          hold_drain    = 1'b1;
          deliver       = 1'b1;
          deliver_instr = hold_instr;
          deliver_pc    = hold_pc;
          state_d       = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    if (branch_enable_i) begin
      pc_d = target_pc;
    end
  end

  // IF/ID register input: bubble on redirect/flush, hold on stall, else load.
  always_comb begin
    if_id_d = if_id_q;
    if (branch_enable_i || clear_if_id_i) begin
      if_id_d = if_id_bubble(NOP_INSTR);
    end else if (deliver) begin
      if_id_d.instr    = deliver_instr;
      if_id_d.pc       = deliver_pc;
      if_id_d.pc_plus4 = deliver_pc + XLEN'(4);
      if_id_d.valid    = 1'b1;
    end else if (!stall_if_id_i) begin
      if_id_d = if_id_bubble(NOP_INSTR);
    end
  end

  // State, PC, kill flag and IF/ID register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= FETCH;
      pc_q     <= RESET_VECTOR;
      req_pc_q <= '0;
      kill_q   <= 1'b0;
      if_id_q  <= if_id_bubble(NOP_INSTR);
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      kill_q   <= kill_d;
      if_id_q  <= if_id_d;
    end
  end

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = pc_q;
  assign instr_id_o       = if_id_q.instr;
  assign pc_id_o          = if_id_q.pc;
  assign pc_plus4_id_o    = if_id_q.pc_plus4;
  assign valid_id_o       = if_id_q.valid;
  assign fetch_busy_o     = (state_q != FETCH);

endmodule
